// File: rtl/toggle_sync_pkg.sv
// rtl/toggle_sync_pkg.sv - shared types and constants for the toggle synchronizer receiver
package toggle_sync_pkg;

    // Shallowest legal synchronizer; deeper chains trade latency for MTBF.
    localparam int SYNC_STAGES_MIN = 2;

    // Default width of the pending-event counter.
    localparam int CNT_W_DEFAULT = 3;

    // IDLE : accepting events normally.
    // STALL: an event is held because the pending counter is full; it is
    //        accepted (and acknowledged) on the first consume.
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop level synchronizer with synchronous active-low reset
//
// Ports:
//   clk  - destination clock
//   rstn - synchronous active-low reset, clears every stage
//   d    - asynchronous input level
//   q    - synchronized level, DEPTH clk edges behind d
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/toggle_sync_rx.sv
// rtl/toggle_sync_rx.sv - receive side of a toggle event synchronizer with pending-event counter
//
// Optional feature macro: TOGGLE_SYNC_RX_STATS_EN adds the evt_cnt output.
//
// Ports:
//   clk2    - destination clock, the only clock of the block
//   rstn    - synchronous active-low reset
//   req_tgl - event toggle from the source domain (asynchronous)
//   ack_tgl - acknowledge toggle back to the source, one flip per accepted event
//   d_out   - high while at least one event is pending
//   d_rdy   - downstream ready; d_out && d_rdy consumes one event
//   pend    - pending-event count
//   ovf     - sticky flag: source toggled again while an event was held
//   evt_cnt - (stats build only) accepted-event count, wraps at 16 bits
module toggle_sync_rx
    import toggle_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk2,
    input  logic             rstn,
    input  logic             req_tgl,
    output logic             ack_tgl,
    output logic             d_out,
    input  logic             d_rdy,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
`ifdef TOGGLE_SYNC_RX_STATS_EN
    ,
    output logic [15:0]      evt_cnt
`endif
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             sync_q;
    logic             sync_prev;
    logic             hist;
    logic             ack_q;
    logic             ovf_q;
    logic [CNT_W-1:0] pend_q;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             evt;
    logic             consume;
    logic             accept;

    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk  (clk2),
        .rstn (rstn),
        .d    (req_tgl),
        .q    (sync_q)
    );

    // hist holds the level of the last accepted toggle, so any difference
    // from the synchronized level is an unaccepted event.
    assign evt     = sync_q ^ hist;
    assign consume = (pend_q != '0) && d_rdy;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (evt) begin
                    // At full, a same-cycle consume frees the slot we need.
                    if ((pend_q != PEND_MAX) || consume) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (consume) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            state     <= IDLE;
            hist      <= 1'b0;
            sync_prev <= 1'b0;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pend_q    <= '0;
        end else begin
            state     <= state_nxt;
            sync_prev <= sync_q;
            if (accept) begin
                hist  <= sync_q;
                ack_q <= ~ack_q;
            end
            // Any movement of the synchronized level while an event is held
            // means the source did not wait for its acknowledge.
            if ((state == STALL) && (sync_q != sync_prev)) begin
                ovf_q <= 1'b1;
            end
            // Accept and consume on one edge cancel out, so the counter can
            // neither exceed PEND_MAX nor go below zero.
            case ({accept, consume})
                2'b10:   pend_q <= pend_q + 1'b1;
                2'b01:   pend_q <= pend_q - 1'b1;
                default: pend_q <= pend_q;
            endcase
        end
    end

    assign ack_tgl = ack_q;
    assign ovf     = ovf_q;
    assign pend    = pend_q;
    assign d_out   = (pend_q != '0);

`ifdef TOGGLE_SYNC_RX_STATS_EN
    logic [15:0] evt_cnt_q;

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            evt_cnt_q <= '0;
        end else if (accept) begin
            evt_cnt_q <= evt_cnt_q + 16'd1;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_toggle_sync_rx.sv
// tb/tb_toggle_sync_rx.sv - self-checking bench for toggle_sync_rx
module tb_toggle_sync_rx;
    import toggle_sync_pkg::*;

    localparam int SS   = 2;
    localparam int CW   = 3;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk2 = 1'b0;
    logic          rstn = 1'b0;
    logic          req_tgl = 1'b0;
    logic          d_rdy = 1'b0;
    logic          ack_tgl;
    logic          d_out;
    logic [CW-1:0] pend;
    logic          ovf;
`ifdef TOGGLE_SYNC_RX_STATS_EN
    logic [15:0]   evt_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    toggle_sync_rx #(
        .SYNC_STAGES (SS),
        .CNT_W       (CW)
    ) dut (
        .clk2    (clk2),
        .rstn    (rstn),
        .req_tgl (req_tgl),
        .ack_tgl (ack_tgl),
        .d_out   (d_out),
        .d_rdy   (d_rdy),
        .pend    (pend),
        .ovf     (ovf)
`ifdef TOGGLE_SYNC_RX_STATS_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    always #30 clk2 = ~clk2;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the receiver sees req_tgl as sampled SS edges ago;
    // events are counted as differences from the last accepted level.
    int q_sync[$];
    int m_taken = 0;
    int m_prev  = 0;
    int m_pend  = 0;
    int m_acks  = 0;
    int m_evt   = 0;
    bit m_stall = 1'b0;
    bit m_ovf   = 1'b0;
    int m_cur;
    bit m_cons;
    bit m_acc;

    initial begin
        repeat (SS) q_sync.push_back(0);
    end

    always @(posedge clk2) begin
        if (!rstn) begin
            q_sync.delete();
            repeat (SS) q_sync.push_back(0);
            m_taken = 0;
            m_prev  = 0;
            m_pend  = 0;
            m_acks  = 0;
            m_evt   = 0;
            m_stall = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_cur  = q_sync[0];
            m_cons = (m_pend != 0) && d_rdy;
            m_acc  = 1'b0;
            if (m_stall) begin
                if (m_cur != m_prev) m_ovf = 1'b1;
                if (m_cons) begin
                    m_acc   = 1'b1;
                    m_stall = 1'b0;
                end
            end else if (m_cur != m_taken) begin
                if (m_pend < PMAX || m_cons) m_acc = 1'b1;
                else m_stall = 1'b1;
            end
            if (m_acc) begin
                m_taken = m_cur;
                m_acks++;
                m_evt = (m_evt + 1) % 65536;
            end
            m_pend = m_pend + int'(m_acc) - int'(m_cons);
            m_prev = m_cur;
            void'(q_sync.pop_front());
            q_sync.push_back(int'(req_tgl));
        end
    end

    always @(negedge clk2) begin
        if (chk_en) begin
            chk("pend", int'(pend), m_pend);
            chk("d_out", int'(d_out), int'(m_pend != 0));
            chk("ack_tgl", int'(ack_tgl), m_acks % 2);
            chk("ovf", int'(ovf), int'(m_ovf));
`ifdef TOGGLE_SYNC_RX_STATS_EN
            chk("evt_cnt", int'(evt_cnt), m_evt);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk2);
    endtask

    initial begin
        int first;
        int hi;
        int base;

        // Reset for two edges.
        step(2);
        rstn = 1'b1;
        chk_en = 1'b1;
        chk("rst_pend", int'(pend), 0);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_ack", int'(ack_tgl), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Single event, downstream ready: latency and one-cycle d_out pulse.
        d_rdy = 1'b1;
        base = m_acks;
        req_tgl = ~req_tgl;
        first = 0;
        hi = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk2);
            if (d_out) begin
                hi++;
                if (first == 0) first = k;
            end
        end
        chk("latency", first, SS + 1);
        chk("d_out_width", hi, 1);
        chk("single_acks", m_acks - base, 1);
        chk("single_pend", int'(pend), 0);

        // Fill the counter with downstream stalled.
        d_rdy = 1'b0;
        base = m_acks;
        for (int i = 0; i < 7; i++) begin
            req_tgl = ~req_tgl;
            step(5);
        end
        chk("full_pend", int'(pend), 7);
        chk("full_d_out", int'(d_out), 1);
        chk("full_acks", m_acks - base, 7);
        chk("model_pend_full", m_pend, 7);

        // Eighth event cannot be accepted.
        req_tgl = ~req_tgl;
        step(6);
        chk("stall_acks", m_acks - base, 7);
        chk("stall_state", int'(dut.state), int'(STALL));
        chk("stall_pend", int'(pend), 7);

        // One consume releases the held event.
        d_rdy = 1'b1;
        step(1);
        d_rdy = 1'b0;
        chk("release_pend", int'(pend), 7);
        chk("release_acks", m_acks - base, 8);
        chk("release_state", int'(dut.state), int'(IDLE));

        // Stall again, then violate the handshake.
        req_tgl = ~req_tgl;
        step(6);
        chk("stall2_state", int'(dut.state), int'(STALL));
        req_tgl = ~req_tgl;
        step(5);
        chk("ovf_set", int'(ovf), 1);
        step(10);
        chk("ovf_sticky", int'(ovf), 1);

        // Drain to five, then reset mid-operation.
        d_rdy = 1'b1;
        step(3);
        d_rdy = 1'b0;
        chk("pend_five", int'(pend), 5);
        rstn = 1'b0;
        req_tgl = 1'b0;
        step(1);
        rstn = 1'b1;
        chk("mid_rst_pend", int'(pend), 0);
        chk("mid_rst_d_out", int'(d_out), 0);
        chk("mid_rst_ack", int'(ack_tgl), 0);
        chk("mid_rst_ovf", int'(ovf), 0);

`ifdef TOGGLE_SYNC_RX_STATS_EN
        for (int i = 0; i < 3; i++) begin
            req_tgl = ~req_tgl;
            step(5);
        end
        chk("stats_three", int'(evt_cnt), 3);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk2);
            if (!rstn) begin
                rstn = 1'b1;
            end else if ($urandom_range(0, 699) == 0) begin
                rstn = 1'b0;
                req_tgl = 1'b0;
            end else begin
                d_rdy = ($urandom_range(0, 3) != 0) ^ (c[9] == 1'b1);
                if (req_tgl == ack_tgl && $urandom_range(0, 3) == 0)
                    req_tgl = ~req_tgl;
                else if ($urandom_range(0, 199) == 0)
                    req_tgl = ~req_tgl;
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
